// File: rtl/serial_tx_sink_if.sv
// Stream handshake between a main_N producer and the serial_tx_sink consumer.
// A word transfers on a rising clock edge where in_stb && in_ack.
interface serial_tx_sink_if;
    logic [31:0] in_data;
    logic        in_stb;
    logic        in_ack;

    modport master (output in_data, output in_stb, input  in_ack);
    modport slave  (input  in_data, input  in_stb, output in_ack);
endinterface

// File: rtl/serial_tx_sink.sv
// serial_tx_sink: takes one 32-bit stb/ack word at a time and sends bits [7:0]
// as an asynchronous frame on tx_o (LSB first, idle high, one stop bit).
// Optional macro PARITY_EN adds an even-parity bit between data bit 7 and the
// stop bit. Without it the frame is plain 8N1.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line high, waiting for in_stb
//   S_ACK    | in_ack high for one cycle; word taken only if in_stb still high
//   S_START  | start bit (low) for DIVISOR cycles
//   S_DATA   | data bits, shift_q[0] on the line, DIVISOR cycles each
//   S_PARITY | even-parity bit for DIVISOR cycles (PARITY_EN only)
//   S_STOP   | stop bit (high) for DIVISOR cycles
module serial_tx_sink #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic             clk,
    input  logic             rst,
    serial_tx_sink_if.slave  in_if,
    output logic             tx_o,
    output logic             busy_o
);
    localparam int DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_START,
        S_DATA,
        S_STOP
`ifdef PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t        state_q;
    logic          tx_q;
    logic          ack_q;
    logic          busy_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
`ifdef PARITY_EN
    logic          parity_q;
`endif

    // Upper stream bits carry nothing for a byte-wide line.
    logic unused_hi;
    assign unused_hi = ^in_if.in_data[31:8];

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign in_if.in_ack = ack_q;

    // Frame sequencer; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (in_if.in_stb) begin
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q <= 1'b0;
                    // A producer that withdrew its strobe did not hand over the word.
                    if (in_if.in_stb) begin
                        shift_q  <= in_if.in_data[7:0];
`ifdef PARITY_EN
                        parity_q <= ^in_if.in_data[7:0];
`endif
                        baud_q   <= RELOAD;
                        idx_q    <= '0;
                        tx_q     <= 1'b0;
                        state_q  <= S_START;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= RELOAD;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= RELOAD;
                        if (idx_q == 3'd7) begin
`ifdef PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (baud_q == '0) begin
                        baud_q  <= RELOAD;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_sink.sv
// Directed bench for serial_tx_sink at DIVISOR=16: expected line bits are
// queued when a word is offered and popped at each mid-bit sample point.
module tb_serial_tx_sink;
    localparam int D = 16;
`ifdef PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PER = FB * D + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    logic busy;

    serial_tx_sink_if ifc();

    serial_tx_sink #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_if  (ifc.slave),
        .tx_o   (tx),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    logic sb[$];
    int ack_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ifc.in_ack === 1'b1) ack_cyc.push_back(cyc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_frame(input logic [7:0] b);
        sb.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb.push_back(b[i]);
`ifdef PARITY_EN
        sb.push_back(^b);
`endif
        sb.push_back(1'b1);
    endtask

    task automatic check_frame(input int t0, input string tag);
        logic e;
        for (int i = 0; i < FB; i++) begin
            wait_until(t0 + 2 + D/2 + D*i);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty at bit %0d", tag, i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s_bit%0d", tag, i), {31'b0, tx}, {31'b0, e});
            end
        end
    endtask

    // One word offered with in_stb held through the ACK cycle and dropped after.
    task automatic single_word(input logic [31:0] d, input string tag);
        int t0;
        step(); step();
        t0 = cyc;
        ack_cyc.delete();
        ifc.in_data = d;
        ifc.in_stb  = 1'b1;
        push_frame(d[7:0]);
        step();
        chk({tag, "_ack_n1"}, {31'b0, ifc.in_ack}, 32'd1);
        chk({tag, "_busy_n1"}, {31'b0, busy}, 32'd1);
        step();
        chk({tag, "_ack_n2"}, {31'b0, ifc.in_ack}, 32'd0);
        chk({tag, "_tx_n2"}, {31'b0, tx}, 32'd0);
        ifc.in_stb = 1'b0;
        check_frame(t0, tag);
        wait_until(t0 + FB*D + 1);
        chk({tag, "_busy_last"}, {31'b0, busy}, 32'd1);
        step();
        chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ack_pulses"}, ack_cyc.size(), 32'd1);
        if (ack_cyc.size() > 0) chk({tag, "_ack_cycle"}, ack_cyc[0], t0 + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bad;
        ifc.in_data = '0;
        ifc.in_stb  = 1'b0;

        // reset state
        #12;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_ack", {31'b0, ifc.in_ack}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) rst = 1'b1;
        step();

        // single word, then parity cases when enabled
        single_word(32'hDEAD_BEA5, "single_a5");
`ifdef PARITY_EN
        single_word(32'h0000_0007, "par_07");
        single_word(32'h0000_0003, "par_03");
`endif

        // back-to-back with strobe held
        step(); step();
        t0 = cyc;
        ack_cyc.delete();
        ifc.in_data = 32'h0000_0000;
        ifc.in_stb  = 1'b1;
        push_frame(8'h00);
        push_frame(8'hFF);
        step(); step();
        ifc.in_data = 32'h0000_00FF;
        check_frame(t0, "b2b_00");
        bad = 0;
        for (int c = t0 + 2 + (FB-1)*D + D/2 + 1; c <= t0 + PER + 1; c++) begin
            wait_until(c);
            if (tx !== 1'b1) bad++;
        end
        chk("b2b_gap_high", bad, 32'd0);
        wait_until(t0 + PER + 2);
        chk("b2b_second_start", {31'b0, tx}, 32'd0);
        ifc.in_stb = 1'b0;
        check_frame(t0 + PER, "b2b_ff");
        wait_until(t0 + PER + 2 + FB*D);
        chk("b2b_idle_after", {31'b0, busy}, 32'd0);
        chk("b2b_ack_count", ack_cyc.size(), 32'd2);
        if (ack_cyc.size() >= 2) chk("b2b_ack_spacing", ack_cyc[1] - ack_cyc[0], PER);

        // strobe withdrawn during the ACK cycle: no transfer
        step(); step();
        t0 = cyc;
        ack_cyc.delete();
        ifc.in_data = 32'h0000_0055;
        ifc.in_stb  = 1'b1;
        step();
        chk("wd_ack_n1", {31'b0, ifc.in_ack}, 32'd1);
        ifc.in_stb = 1'b0;
        step();
        chk("wd_ack_n2", {31'b0, ifc.in_ack}, 32'd0);
        chk("wd_busy_n2", {31'b0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("wd_line_idle", bad, 32'd0);
        chk("wd_ack_pulses", ack_cyc.size(), 32'd1);

        // data changes before the ACK edge; strobe drops right after transfer
        step();
        t0 = cyc;
        ifc.in_data = 32'hFFFF_FF11;
        ifc.in_stb  = 1'b1;
        push_frame(8'h3C);
        step();
        ifc.in_data = 32'h1234_563C;
        step();
        ifc.in_data = 32'h0000_0099;
        ifc.in_stb  = 1'b0;
        check_frame(t0, "late_data");
        wait_until(t0 + FB*D + 3);
        chk("late_idle", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of the data bits
        step();
        t0 = cyc;
        ifc.in_data = 32'h0000_00F0;
        ifc.in_stb  = 1'b1;
        step(); step();
        ifc.in_stb = 1'b0;
        wait_until(t0 + 50);
        chk("mid_pre_tx", {31'b0, tx}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_ack", {31'b0, ifc.in_ack}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
